// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared state encoding and constants for the BRAM port arbiter
package bram_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
  localparam int C_NUM_REQ = 2;
  localparam logic C_LAST_RST = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant, favouring the requester that did not win last
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       vld_o
);
  assign gnt_o[0] = req_i[0] & (~req_i[1] | last_i);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);
  assign vld_o    = |req_i;
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one BRAM port between two requesters with round-robin grants
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int C_PORT_DWIDTH = 32,
  parameter int C_PORT_AWIDTH = 32,
  parameter int C_NUM_WE      = 4
) (
  input  logic                     BRAM_Clk,
  input  logic                     BRAM_Rst,
  input  logic                     Req_0,
  input  logic                     Req_1,
  input  logic [0:C_NUM_WE-1]      WE_0,
  input  logic [0:C_NUM_WE-1]      WE_1,
  input  logic [0:C_PORT_AWIDTH-1] Addr_0,
  input  logic [0:C_PORT_AWIDTH-1] Addr_1,
  input  logic [0:C_PORT_DWIDTH-1] Wdata_0,
  input  logic [0:C_PORT_DWIDTH-1] Wdata_1,
  output logic                     Ack_0,
  output logic                     Ack_1,
  output logic [0:C_PORT_DWIDTH-1] Rdata_0,
  output logic [0:C_PORT_DWIDTH-1] Rdata_1,
  output logic                     BRAM_EN,
  output logic [0:C_NUM_WE-1]      BRAM_WEN,
  output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Din
);
  state_t                     state_q;
  logic                       last_q, rd_q, en_q, ack0_q, ack1_q;
  logic [0:C_NUM_WE-1]        wen_q;
  logic [0:C_PORT_AWIDTH-1]   addr_q;
  logic [0:C_PORT_DWIDTH-1]   dout_q, rdata0_q, rdata1_q;
  logic [C_NUM_REQ-1:0]       elig, gnt;
  logic                       gnt_vld;
  logic [0:C_NUM_WE-1]        we_sel;
  // a requester whose Ack is showing is masked so a late Req drop cannot re-issue
  assign elig   = {Req_1 & ~ack1_q, Req_0 & ~ack0_q};
  assign we_sel = gnt[1] ? WE_1 : WE_0;
  rr_arb2 u_rr (
    .req_i  (elig),
    .last_i (last_q),
    .gnt_o  (gnt),
    .vld_o  (gnt_vld)
  );
  // access FSM; last_q doubles as the latched winner of the in-flight access
  always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
    if (BRAM_Rst) begin
      state_q  <= ST_IDLE;
      last_q   <= C_LAST_RST;
      rd_q     <= 1'b0;
      en_q     <= 1'b0;
      wen_q    <= '0;
      addr_q   <= '0;
      dout_q   <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (gnt_vld) begin
          state_q <= ST_ACCESS;
          last_q  <= gnt[1];
          rd_q    <= we_sel == '0;
          en_q    <= 1'b1;
          wen_q   <= we_sel;
          addr_q  <= gnt[1] ? Addr_1 : Addr_0;
          dout_q  <= gnt[1] ? Wdata_1 : Wdata_0;
        end
        ST_ACCESS: begin
          state_q <= ST_RESP;
          en_q    <= 1'b0;
          wen_q   <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          ack0_q  <= ~last_q;
          ack1_q  <= last_q;
          if (rd_q && !last_q) rdata0_q <= BRAM_Din;
          if (rd_q && last_q) rdata1_q <= BRAM_Din;
        end
      endcase
    end
  end
  assign Ack_0     = ack0_q;
  assign Ack_1     = ack1_q;
  assign Rdata_0   = rdata0_q;
  assign Rdata_1   = rdata1_q;
  assign BRAM_EN   = en_q;
  assign BRAM_WEN  = wen_q;
  assign BRAM_Addr = addr_q;
  assign BRAM_Dout = dout_q;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed self-checking bench with a behavioural BRAM port model
module tb_bram_port_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        Req_0 = 1'b0, Req_1 = 1'b0;
  logic [0:3]  WE_0 = '0, WE_1 = '0;
  logic [0:31] Addr_0 = '0, Addr_1 = '0, Wdata_0 = '0, Wdata_1 = '0;
  logic        Ack_0, Ack_1, BRAM_EN;
  logic [0:31] Rdata_0, Rdata_1, BRAM_Addr, BRAM_Dout, din;
  logic [0:3]  BRAM_WEN;
  logic [0:31] mem [0:63];
  int          cyc = 0, en_cnt = 0, total = 0, fails = 0;
  int          aq[$], at[$];

  bram_port_arbiter dut (
    .BRAM_Clk(clk), .BRAM_Rst(rst),
    .Req_0(Req_0), .Req_1(Req_1), .WE_0(WE_0), .WE_1(WE_1),
    .Addr_0(Addr_0), .Addr_1(Addr_1), .Wdata_0(Wdata_0), .Wdata_1(Wdata_1),
    .Ack_0(Ack_0), .Ack_1(Ack_1), .Rdata_0(Rdata_0), .Rdata_1(Rdata_1),
    .BRAM_EN(BRAM_EN), .BRAM_WEN(BRAM_WEN), .BRAM_Addr(BRAM_Addr),
    .BRAM_Dout(BRAM_Dout), .BRAM_Din(din)
  );

  always #5 clk = ~clk;

  // synchronous BRAM, read-first, one-cycle read latency; preloaded during the first reset
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && cyc < 3) begin
      mem[4] <= 32'hDEADBEEF;
      mem[8] <= 32'hAAAAAAAA;
    end else if (BRAM_EN) begin
      en_cnt <= en_cnt + 1;
      din <= mem[BRAM_Addr[24:29]];
      for (int i = 0; i < 4; i++)
        if (BRAM_WEN[i]) mem[BRAM_Addr[24:29]][8*i +: 8] <= BRAM_Dout[8*i +: 8];
    end
  end

  always @(negedge clk) begin
    if (Ack_0) begin aq.push_back(0); at.push_back(cyc); end
    if (Ack_1) begin aq.push_back(1); at.push_back(cyc); end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_acks(input int n, input string tag);
    int k = 0;
    while (aq.size() < n && k < 40) begin tick(); k++; end
    if (aq.size() < n) chk(tag, 64'(aq.size()), 64'(n));
  endtask

  initial begin
    int base, e0;
    #1;
    chk("rst_en", BRAM_EN, 0);
    chk("rst_ack", {Ack_0, Ack_1}, 0);
    tick(); tick(); tick();
    chk("rst_addr", BRAM_Addr, 0);
    chk("rst_rdata", {Rdata_0, Rdata_1}, 0);
    rst = 1'b0;
    tick();
    // read after reset
    Req_0 = 1'b1; Addr_0 = 32'h10;
    tick();
    chk("rd_en", BRAM_EN, 1);
    chk("rd_addr", BRAM_Addr, 32'h10);
    chk("rd_wen", BRAM_WEN, 0);
    tick();
    chk("rd_en_off", BRAM_EN, 0);
    chk("rd_no_early_ack", Ack_0, 0);
    tick();
    chk("rd_ack", {Ack_0, Ack_1}, 2'b10);
    chk("rd_data", Rdata_0, 32'hDEADBEEF);
    chk("rd_other", Rdata_1, 0);
    Req_0 = 1'b0;
    tick();
    chk("rd_ack_once", Ack_0, 0);
    chk("rd_hold", Rdata_0, 32'hDEADBEEF);
    // byte-masked write by requester 1
    Req_1 = 1'b1; WE_1 = 4'b0011; Addr_1 = 32'h20; Wdata_1 = 32'h11223344;
    tick();
    chk("wr_en", BRAM_EN, 1);
    chk("wr_wen", BRAM_WEN, 4'b0011);
    chk("wr_dout", BRAM_Dout, 32'h11223344);
    tick();
    chk("wr_wen_off", {BRAM_EN, BRAM_WEN}, 0);
    chk("wr_addr_hold", BRAM_Addr, 32'h20);
    tick();
    chk("wr_ack", {Ack_0, Ack_1}, 2'b01);
    chk("wr_rdata_keep", Rdata_1, 0);
    Req_1 = 1'b0; WE_1 = '0;
    tick();
    Req_1 = 1'b1;
    tick(); tick(); tick();
    chk("wr_readback", Rdata_1, 32'hAAAA3344);
    chk("wr_rb_ack", Ack_1, 1);
    Req_1 = 1'b0;
    tick();
    // contention, pointer now favours requester 0
    base = aq.size(); e0 = en_cnt;
    Req_0 = 1'b1; Req_1 = 1'b1;
    wait_acks(base + 6, "cont_timeout");
    Req_0 = 1'b0; Req_1 = 1'b0;
    for (int i = 0; i < 6 && base + i < aq.size(); i++) begin
      chk($sformatf("cont_order%0d", i), 64'(aq[base+i]), 64'(i % 2));
      if (i > 0) chk($sformatf("cont_gap%0d", i), 64'(at[base+i] - at[base+i-1]), 3);
    end
    tick(); tick(); tick(); tick();
    chk("cont_accesses", 64'(en_cnt - e0), 6);
    chk("cont_acks", 64'(aq.size() - base), 6);
    // late Req drop
    base = aq.size(); e0 = en_cnt;
    Req_0 = 1'b1; Addr_0 = 32'h10;
    wait_acks(base + 1, "late_timeout");
    tick();
    Req_0 = 1'b0;
    tick(); tick(); tick(); tick();
    chk("late_accesses", 64'(en_cnt - e0), 1);
    chk("late_acks", 64'(aq.size() - base), 1);
    chk("late_data", Rdata_0, 32'hDEADBEEF);
    // reset during ACCESS
    base = aq.size();
    Req_0 = 1'b1; Addr_0 = 32'h30;
    tick();
    chk("mid_en", BRAM_EN, 1);
    rst = 1'b1;
    #1;
    chk("mid_en_clr", {BRAM_EN, BRAM_WEN}, 0);
    chk("mid_addr_clr", BRAM_Addr, 0);
    chk("mid_rdata_clr", {Rdata_0, Rdata_1}, 0);
    Req_0 = 1'b0;
    tick(); tick(); tick();
    chk("mid_no_ack", 64'(aq.size() - base), 0);
    rst = 1'b0;
    tick();
    Req_0 = 1'b1; Req_1 = 1'b1; Addr_0 = 32'h10; Addr_1 = 32'h20;
    tick();
    chk("post_first_addr", BRAM_Addr, 32'h10);
    wait_acks(base + 1, "post_timeout0");
    if (aq.size() > base) chk("post_first", 64'(aq[base]), 0);
    Req_0 = 1'b0;
    wait_acks(base + 2, "post_timeout1");
    if (aq.size() > base + 1) chk("post_second", 64'(aq[base+1]), 1);
    chk("post_rdata1", Rdata_1, 32'hAAAA3344);
    Req_1 = 1'b0;
    tick();
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
